cnt_burst_sched: RTL and testbench
==================================

Name: cnt_burst_sched

Overview:
- Round-robin scheduler that shares one base/addr/cnt address-counter datapath between N requesters.
- Each requester asks for a burst with a start address and a beat count.
- The scheduler loads the counter, lets it free-run for exactly that many beats, then hands it to the next requester.
- Sits directly in front of the counter: drives its en/inp inputs and watches its cnt output.

Parameters:
- W, 16, datapath width (address, length, counter).
- N, 2, number of requesters (2..8).
- IW, $clog2(N) (min 1), requester index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester burst request, level; must be held until gnt.
- req_base  input  N*W  packed start addresses; slice i belongs to requester i.
- req_len  input  N*W  packed burst lengths in beats; 0 is legal.
- gnt  output  N  one-hot grant; high while requester owns the counter.
- done  output  N  one-cycle pulse to the owner when its burst completes.
- busy  output  1  counter is owned (state != IDLE).
- ctr_en  output  1  to counter en: load ctr_inp this cycle.
- ctr_inp  output  W  to counter inp: start address.
- ctr_cnt  input  W  from counter cnt: beats elapsed since the last load.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; gnt=0, done=0, busy=0, ctr_en=0, ctr_inp=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - Latched id/len=0.
  - Reset mid-burst aborts immediately; no done pulse is issued. The counter is reset by the same rst.
- States: IDLE, LOAD, BURST. All outputs are registered except busy, which is decoded from state.
- IDLE:
  - If req != 0, pick the first set bit scanning from ptr upward, mod N.
  - Latch id and len_q = req_len[id].
  - Next state LOAD; gnt[id]=1 from next cycle.
  - ptr <= (id+1) mod N.
  - req is sampled only in IDLE.
- LOAD (exactly 1 cycle):
  - ctr_en=1, ctr_inp=req_base[id] sampled at grant.
  - After this edge the counter holds addr=base, cnt=0.
  - len_q==0: go to IDLE, done[id] pulses in that IDLE cycle, gnt drops.
  - Otherwise go to BURST.
- BURST:
  - ctr_en=0, so the counter increments addr and cnt every cycle. Beat k has addr=base+k, cnt=k.
  - When ctr_cnt == len_q-1 (last beat): next state IDLE, gnt drops, done[id] pulses in the following cycle.
  - The burst therefore occupies exactly len_q BURST cycles.
- Back-to-back: arbitration runs in the same IDLE cycle in which done pulses.
  - Minimum turnaround is 1 IDLE cycle between bursts.
  - A new requester's LOAD therefore follows 1 cycle after the previous owner's last beat.
- Request changes:
  - Deasserting req or changing req_base/req_len after grant has no effect on the current burst.
  - A requester must deassert req on done or it is re-arbitrated.
- Width rules:
  - len_q-1 computed in W bits; the len_q==0 case never reaches BURST.
  - Addresses wrap mod 2^W inside the counter; the scheduler does not check for wrap.
  - Max burst length is 2^W-1.
- Invariants (formal asserts in the module):
  - gnt is one-hot-or-zero; done is one-hot-or-zero.
  - ctr_en implies state==LOAD.
  - done[i] implies gnt[i] was high in the previous cycle.
  - In BURST, ctr_cnt < len_q.

Decomposition:
- Shared package cnt_sched_pkg:
  - state enum {IDLE, LOAD, BURST}.
  - Default W.
  - Helper function for mod-N increment.
- One sub-module, rr_pick:
  - Purely combinational priority scan from a pointer.
  - Inputs req and ptr; outputs valid and id.
- FSM, latches and counter handshake stay in cnt_burst_sched.

Test Plan:
1. Single burst: N=2, req=01, base0=0x8000, len0=3 → LOAD 1 cycle with ctr_inp=0x8000, ctr_en=1. Counter addr goes 0x8000, 0x8001, 0x8002 with cnt 0,1,2; gnt=01 for 4 cycles; done=01 one cycle later.
2. Contention/fairness: req=11 held continuously, len0=len1=2 → grants alternate 01,10,01,10; each burst is LOAD+2 BURST cycles with a 1-cycle IDLE gap; done pulses alternate.
3. Zero length: req=10, base1=0x0010, len1=0 → LOAD with ctr_inp=0x0010, then IDLE. done=10 pulses 2 cycles after req, with no BURST cycle.
4. Wrap: base0=0xFFFE, len0=4 → beat addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; completes normally with done=01.
5. Reset mid-burst: len0=10, assert rst at beat 5 → same cycle gnt=0, busy=0, ctr_en=0, no done. After release with req=10, requester 1 wins because ptr=0 scans from 0 and only req[1] is set.
6. Late change: after gnt=01, change base0/len0 and drop req0 → burst still uses the original values; exactly one done.

Source files
------------

// File: rtl/cnt_sched_pkg.sv
// cnt_sched_pkg: shared FSM state type, default datapath width and mod-N increment helper
package cnt_sched_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, BURST} state_t;
  localparam int W_DEF = 16;
  function automatic int inc_mod(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin scan; id is the first set req bit at or after ptr, mod N
//   req[N] requests, ptr[IW] start index -> valid (any request), id[IW] winner
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] id
);
  logic [IW-1:0] cand [N];
  for (genvar k = 0; k < N; k++) begin : g_c
    logic [IW:0] s;
    assign s       = {1'b0, ptr} + (IW+1)'(k);
    assign cand[k] = (s >= (IW+1)'(N)) ? IW'(s - (IW+1)'(N)) : IW'(s);
  end
  assign valid = |req;
  // Scan from the far end so the candidate closest to ptr is written last and wins.
  always_comb begin
    id = '0;
    for (int k = N - 1; k >= 0; k--) if (req[cand[k]]) id = cand[k];
  end
endmodule

// File: rtl/cnt_burst_sched.sv
// cnt_burst_sched: round-robin burst scheduler sharing one base/addr/cnt counter among N requesters
//   req/req_base/req_len in (packed per requester) -> gnt one-hot owner, done completion pulse,
//   busy; ctr_en/ctr_inp drive the counter load, ctr_cnt is its beat count
module cnt_burst_sched
  import cnt_sched_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_base,
  input  logic [N*W-1:0] req_len,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic           ctr_en,
  output logic [W-1:0]   ctr_inp,
  input  logic [W-1:0]   ctr_cnt
);
  state_t        state, state_d;
  logic [IW-1:0] ptr, id_q, pick_id;
  logic [W-1:0]  len_q;
  logic          pick_v, grant, finish, last_beat;
  rr_pick #(.N(N), .IW(IW)) u_pick (.req(req), .ptr(ptr), .valid(pick_v), .id(pick_id));
  // len_q is never 0 in BURST, so len_q-1 cannot underflow there.
  assign last_beat = ctr_cnt == len_q - W'(1);
  assign busy      = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end
  always_comb begin
    grant   = state == IDLE && pick_v;
    finish  = (state == LOAD && len_q == '0) || (state == BURST && last_beat);
    state_d = grant ? LOAD
            : (state == LOAD && len_q != '0) ? BURST
            : (state == BURST && !last_beat) ? BURST
            : IDLE;
  end
  // Outputs are registered one cycle ahead: the grant edge already presents the LOAD values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= '0;
      done    <= '0;
      ctr_en  <= 1'b0;
      ctr_inp <= '0;
      id_q    <= '0;
      len_q   <= '0;
      ptr     <= '0;
    end else begin
      ctr_en <= grant;
      done   <= finish ? N'(1) << id_q : '0;
      gnt    <= grant ? N'(1) << pick_id : finish ? '0 : gnt;
      if (grant) begin
        id_q    <= pick_id;
        len_q   <= req_len[int'(pick_id)*W +: W];
        ctr_inp <= req_base[int'(pick_id)*W +: W];
        ptr     <= IW'(inc_mod(int'(pick_id), N));
      end
    end
  end
  a_gnt_oh:   assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_done_oh:  assert property (@(posedge clk) disable iff (rst) $onehot0(done));
  a_en_load:  assert property (@(posedge clk) disable iff (rst) ctr_en |-> state == LOAD);
  a_done_gnt: assert property (@(posedge clk) disable iff (rst) (done & ~$past(gnt)) == '0);
  a_cnt_len:  assert property (@(posedge clk) disable iff (rst) state == BURST |-> ctr_cnt < len_q);
endmodule

// File: tb/tb_cnt_burst_sched.sv
// tb_cnt_burst_sched: directed checks of cnt_burst_sched driving a behavioural base/addr/cnt counter
module tb_cnt_burst_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [31:0] req_base = '0;
  logic [31:0] req_len = '0;
  logic [1:0]  gnt, done;
  logic        busy, ctr_en;
  logic [15:0] ctr_inp, addr, cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  cnt_burst_sched #(.W(16), .N(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_base(req_base), .req_len(req_len),
    .gnt(gnt), .done(done), .busy(busy), .ctr_en(ctr_en), .ctr_inp(ctr_inp), .ctr_cnt(cnt)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      cnt  <= '0;
    end else if (ctr_en) begin
      addr <= ctr_inp;
      cnt  <= '0;
    end else begin
      addr <= addr + 16'd1;
      cnt  <= cnt + 16'd1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(ctr_en), 0);
    chk("rst_inp", 32'(ctr_inp), 0);
    tick();
    rst = 1'b0;
    tick();
    // 1: single burst, len 3
    req = 2'b01; req_base[15:0] = 16'h8000; req_len[15:0] = 16'd3;
    tick();
    chk("t1_load_gnt", 32'(gnt), 1);
    chk("t1_load_en", 32'(ctr_en), 1);
    chk("t1_load_inp", 32'(ctr_inp), 32'h8000);
    chk("t1_load_busy", 32'(busy), 1);
    req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_addr", 32'(addr), 32'h8000 + 32'(k));
      chk("t1_cnt", 32'(cnt), 32'(k));
      chk("t1_gnt", 32'(gnt), 1);
      chk("t1_en", 32'(ctr_en), 0);
    end
    tick();
    chk("t1_done", 32'(done), 1);
    chk("t1_gnt_drop", 32'(gnt), 0);
    chk("t1_busy", 32'(busy), 0);
    tick();
    chk("t1_done_pulse", 32'(done), 0);
    // 2: contention, ptr is 1 after the first burst so requester 1 leads
    req = 2'b11;
    req_base = {16'h0200, 16'h0100};
    req_len  = {16'd2, 16'd2};
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("t2_load_gnt", 32'(gnt), (b % 2 == 0) ? 2 : 1);
      chk("t2_load_inp", 32'(ctr_inp), (b % 2 == 0) ? 32'h200 : 32'h100);
      chk("t2_load_en", 32'(ctr_en), 1);
      if (b == 3) req = 2'b00;
      tick();
      chk("t2_b0_addr", 32'(addr), (b % 2 == 0) ? 32'h200 : 32'h100);
      tick();
      chk("t2_b1_cnt", 32'(cnt), 1);
      chk("t2_b1_gnt", 32'(gnt), (b % 2 == 0) ? 2 : 1);
      tick();
      chk("t2_idle_gnt", 32'(gnt), 0);
      chk("t2_idle_busy", 32'(busy), 0);
      chk("t2_done", 32'(done), (b % 2 == 0) ? 2 : 1);
    end
    tick();
    chk("t2_quiet_busy", 32'(busy), 0);
    chk("t2_quiet_done", 32'(done), 0);
    // 3: zero-length burst
    req = 2'b10; req_base[31:16] = 16'h0010; req_len[31:16] = 16'd0;
    tick();
    chk("t3_load_gnt", 32'(gnt), 2);
    chk("t3_load_inp", 32'(ctr_inp), 32'h10);
    chk("t3_load_en", 32'(ctr_en), 1);
    req = 2'b00;
    tick();
    chk("t3_done", 32'(done), 2);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_gnt", 32'(gnt), 0);
    tick();
    chk("t3_done_pulse", 32'(done), 0);
    // 4: address wrap
    req = 2'b01; req_base[15:0] = 16'hFFFE; req_len[15:0] = 16'd4;
    tick();
    chk("t4_load_inp", 32'(ctr_inp), 32'hFFFE);
    req = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_addr", 32'(addr), k == 0 ? 32'hFFFE : k == 1 ? 32'hFFFF : k == 2 ? 32'h0 : 32'h1);
      chk("t4_gnt", 32'(gnt), 1);
    end
    tick();
    chk("t4_done", 32'(done), 1);
    chk("t4_gnt_drop", 32'(gnt), 0);
    // 5: reset mid-burst, then requester 1 alone
    req = 2'b01; req_base[15:0] = 16'h4000; req_len[15:0] = 16'd10;
    tick();
    req = 2'b00;
    for (int k = 0; k < 6; k++) tick();
    chk("t5_beat5_cnt", 32'(cnt), 5);
    chk("t5_beat5_gnt", 32'(gnt), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_gnt", 32'(gnt), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_en", 32'(ctr_en), 0);
    chk("t5_rst_done", 32'(done), 0);
    tick();
    chk("t5_rst_done2", 32'(done), 0);
    rst = 1'b0;
    req = 2'b10; req_base[31:16] = 16'h0040; req_len[31:16] = 16'd1;
    tick();
    chk("t5_post_gnt", 32'(gnt), 2);
    chk("t5_post_inp", 32'(ctr_inp), 32'h40);
    req = 2'b00;
    tick();
    chk("t5_post_addr", 32'(addr), 32'h40);
    tick();
    chk("t5_post_done", 32'(done), 2);
    // 6: late change of request inputs after grant
    req = 2'b01; req_base[15:0] = 16'h3000; req_len[15:0] = 16'd2;
    tick();
    chk("t6_load_gnt", 32'(gnt), 1);
    req = 2'b00; req_base[15:0] = 16'h7777; req_len[15:0] = 16'd5;
    tick();
    chk("t6_b0_addr", 32'(addr), 32'h3000);
    tick();
    chk("t6_b1_addr", 32'(addr), 32'h3001);
    tick();
    chk("t6_done", 32'(done), 1);
    chk("t6_gnt", 32'(gnt), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_more_done", 32'(done), 0);
      chk("t6_idle", 32'(busy), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
